updn_counter_driver: RTL and testbench

Command sequencer that sits in front of the 16-bit up/down counter and drives its control pins. It accepts one command at a time over a valid/ready handshake: load, count up N, count down N, or seek to a target value by the shortest wrap-around path. It generates the counter's active-low load strobe, direction and enable, watches the counter's output, and returns the final count with a one-cycle done pulse. This block is the counter's only controller.

---
 rtl/updn_counter_driver.sv | 113 +++++++++++
 tb/tb_updn_counter_driver.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/updn_counter_driver.sv
// Command sequencer for an up/down counter: LOAD, UP N, DOWN N, SEEK target (shortest wrap path).
// Latency: controls change the cycle after acceptance; done at N+2 (LOAD: 3, zero steps: 2).
// Backpressure: one command in flight; cmd_ready only in IDLE, so cmd_valid is ignored while busy.
module updn_counter_driver #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             ld_cnt,
    output logic             updn_cnt,
    output logic             count_enb,
    output logic [WIDTH-1:0] cnt_d,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, EXEC, SETTLE, DONE} state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_SEEK = 2'b11;

    state_t           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] steps;
    logic             step_up;

    // A seek distance with the MSB set (including the exact half-range tie) goes down.
    always_comb begin
        diff    = cmd_data - cnt_q;
        steps   = cmd_data;
        step_up = (cmd_op == OP_UP);
        if (cmd_op == OP_SEEK) begin
            steps   = diff[WIDTH-1] ? ('0 - diff) : diff;
            step_up = ~diff[WIDTH-1];
        end
    end

    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_LOAD;
            remaining <= '0;
            ld_cnt    <= 1'b1;
            updn_cnt  <= 1'b0;
            count_enb <= 1'b0;
            cnt_d     <= '0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q <= cmd_op;
                        if (cmd_op == OP_LOAD) begin
                            ld_cnt <= 1'b0;
                            cnt_d  <= cmd_data;
                            state  <= EXEC;
                        end else begin
                            remaining <= steps;
                            // A zero-distance seek has no direction, so the pin keeps its value.
                            if (cmd_op != OP_SEEK || steps != '0) begin
                                updn_cnt <= step_up;
                            end
                            if (steps == '0) begin
                                state <= SETTLE;
                            end else begin
                                count_enb <= 1'b1;
                                state     <= EXEC;
                            end
                        end
                    end
                end
                EXEC: begin
                    if (op_q == OP_LOAD) begin
                        ld_cnt <= 1'b1;
                        state  <= SETTLE;
                    end else begin
                        remaining <= remaining - WIDTH'(1);
                        if (remaining == WIDTH'(1)) begin
                            count_enb <= 1'b0;
                            state     <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    result <= cnt_q;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updn_counter_driver.sv
// Directed bench for updn_counter_driver: a 16-bit and a 4-bit instance, each driving a behavioural counter.
module tb_updn_counter_driver;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_SEEK = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid16, valid4;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [3:0]  cmd_data4;

    logic        ready16, ld16, dir16, enb16, busy16, done16;
    logic [15:0] cnt_d16, result16;
    logic [15:0] cq16 = 16'h0000;

    logic        ready4, ld4, dir4, enb4, busy4, done4;
    logic [3:0]  cnt_d4, result4;
    logic [3:0]  cq4 = 4'h0;

    logic        sel4;
    logic        s_ready, s_ld, s_dir, s_enb, s_busy, s_done;
    logic [15:0] s_cnt_d, s_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign cmd_data4 = cmd_data[3:0];

    updn_counter_driver #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(valid16), .cmd_ready(ready16),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cnt_q(cq16),
        .ld_cnt(ld16), .updn_cnt(dir16), .count_enb(enb16), .cnt_d(cnt_d16),
        .busy(busy16), .done(done16), .result(result16)
    );

    updn_counter_driver #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .cmd_valid(valid4), .cmd_ready(ready4),
        .cmd_op(cmd_op), .cmd_data(cmd_data4), .cnt_q(cq4),
        .ld_cnt(ld4), .updn_cnt(dir4), .count_enb(enb4), .cnt_d(cnt_d4),
        .busy(busy4), .done(done4), .result(result4)
    );

    // The counters are never reset by the sequencer, so they carry no reset here either.
    always @(posedge clk) begin
        if (!ld16)     cq16 <= cnt_d16;
        else if (enb16) cq16 <= dir16 ? cq16 + 16'd1 : cq16 - 16'd1;
        if (!ld4)      cq4 <= cnt_d4;
        else if (enb4) cq4 <= dir4 ? cq4 + 4'd1 : cq4 - 4'd1;
    end

    always_comb begin
        s_ready  = sel4 ? ready4 : ready16;
        s_ld     = sel4 ? ld4    : ld16;
        s_dir    = sel4 ? dir4   : dir16;
        s_enb    = sel4 ? enb4   : enb16;
        s_busy   = sel4 ? busy4  : busy16;
        s_done   = sel4 ? done4  : done16;
        s_cnt_d  = sel4 ? {12'h000, cnt_d4}  : cnt_d16;
        s_result = sel4 ? {12'h000, result4} : result16;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in cycle 1 (the cycle after acceptance); returns in the cycle after done.
    task automatic monitor(input logic [1:0] op, input logic [15:0] data, input int n_enb,
                           input logic dir, input int done_cyc, input logic [15:0] res,
                           input string tag);
        int c = 1;
        int bad = 0;
        int done_at = -1;
        while (done_at < 0 && c <= done_cyc + 20) begin
            if (s_enb !== (c <= n_enb)) bad++;
            if (c <= n_enb && s_dir !== dir) bad++;
            if (s_ld !== !(op == OP_LOAD && c == 1)) bad++;
            if (op == OP_LOAD && c == 1 && s_cnt_d !== data) bad++;
            if (s_busy !== 1'b1) bad++;
            if (s_done) done_at = c;
            else begin
                tick();
                c++;
            end
        end
        chk({tag, " ctl_pattern_errors"}, bad, 0);
        chk({tag, " done_cycle"}, done_at, done_cyc);
        chk({tag, " result"}, s_result, res);
        tick();
        chk({tag, " done_one_cycle"}, s_done, 1'b0);
        chk({tag, " result_held"}, s_result, res);
    endtask

    task automatic issue_cmd(input logic w4, input logic [1:0] op, input logic [15:0] data,
                             input int n_enb, input logic dir, input int done_cyc,
                             input logic [15:0] res, input string tag);
        int guard = 0;
        sel4 = w4;
        #0;
        while (!s_ready && guard < 50) begin
            tick();
            guard++;
        end
        chk({tag, " ready_before_issue"}, s_ready, 1'b1);
        cmd_op   = op;
        cmd_data = data;
        if (w4) valid4 = 1'b1; else valid16 = 1'b1;
        tick();
        valid4  = 1'b0;
        valid16 = 1'b0;
        monitor(op, data, n_enb, dir, done_cyc, res, tag);
    endtask

    initial begin
        rst = 1'b1; valid16 = 1'b0; valid4 = 1'b0; sel4 = 1'b0;
        cmd_op = OP_LOAD; cmd_data = 16'h0000;
        tick();
        tick();
        chk("ready_in_reset", ready16, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst ready", ready16, 1'b1);
        chk("rst ld_cnt", ld16, 1'b1);
        chk("rst count_enb", enb16, 1'b0);
        chk("rst updn_cnt", dir16, 1'b0);
        chk("rst cnt_d", cnt_d16, 16'h0000);
        chk("rst done", done16, 1'b0);
        chk("rst busy", busy16, 1'b0);
        chk("rst result", result16, 16'h0000);
        chk("rst result4", result4, 4'h0);

        issue_cmd(1'b0, OP_LOAD, 16'h1234, 0, 1'b0, 3, 16'h1234, "load_1234");
        issue_cmd(1'b0, OP_LOAD, 16'hFFFE, 0, 1'b0, 3, 16'hFFFE, "load_fffe");
        issue_cmd(1'b0, OP_UP,   16'd3,    3, 1'b1, 5, 16'h0001, "up3_wrap");
        issue_cmd(1'b0, OP_LOAD, 16'h0042, 0, 1'b0, 3, 16'h0042, "load_0042");
        issue_cmd(1'b0, OP_DOWN, 16'd0,    0, 1'b0, 2, 16'h0042, "down0");
        issue_cmd(1'b0, OP_LOAD, 16'h0005, 0, 1'b0, 3, 16'h0005, "load_0005");
        issue_cmd(1'b0, OP_SEEK, 16'hFFFD, 8, 1'b0, 10, 16'hFFFD, "seek_down8");
        issue_cmd(1'b0, OP_SEEK, 16'hFFFD, 0, 1'b0, 2, 16'hFFFD, "seek_zero");
        issue_cmd(1'b0, OP_LOAD, 16'h0010, 0, 1'b0, 3, 16'h0010, "load_0010");
        issue_cmd(1'b0, OP_SEEK, 16'h0013, 3, 1'b1, 5, 16'h0013, "seek_up3");
        issue_cmd(1'b1, OP_SEEK, 16'h0008, 8, 1'b0, 10, 16'h0008, "w4_seek_tie");

        // A second command held valid during a busy UP 5 must wait until after done.
        issue_cmd(1'b0, OP_LOAD, 16'h0000, 0, 1'b0, 3, 16'h0000, "load_0000");
        sel4 = 1'b0;
        cmd_op = OP_UP; cmd_data = 16'd5; valid16 = 1'b1;
        tick();
        cmd_op = OP_LOAD; cmd_data = 16'h00AA;
        monitor(OP_UP, 16'd5, 5, 1'b1, 7, 16'h0005, "b2b_up5");
        chk("b2b ready_after_done", ready16, 1'b1);
        tick();
        valid16 = 1'b0;
        monitor(OP_LOAD, 16'h00AA, 0, 1'b0, 3, 16'h00AA, "b2b_load");

        // Reset during UP 10 after four steps; the counter keeps those steps (0xAA + 4).
        cmd_op = OP_UP; cmd_data = 16'd10; valid16 = 1'b1;
        tick();
        valid16 = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("midrst ld_cnt", ld16, 1'b1);
        chk("midrst count_enb", enb16, 1'b0);
        chk("midrst done", done16, 1'b0);
        chk("midrst result", result16, 16'h0000);
        chk("midrst busy", busy16, 1'b0);
        chk("midrst ready_low", ready16, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst ready_after_release", ready16, 1'b1);
        chk("midrst counter_kept", cq16, 16'h00AE);
        issue_cmd(1'b0, OP_SEEK, 16'h00AA, 4, 1'b0, 6, 16'h00AA, "seek_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
